// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Purpose : Shared definitions for the ALU issue controller: ALU operation
//           codes, exception codes, instruction opcodes and the sequencer
//           state type.
// Revision: 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU operation codes as seen on alu_operation
  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_INC = 4'h2,
    ALU_DEC = 4'h3,
    ALU_AND = 4'h4,
    ALU_OR  = 4'h5,
    ALU_XOR = 4'h6,
    ALU_NOT = 4'h7,
    ALU_SLL = 4'h8,
    ALU_SRL = 4'h9,
    ALU_SLT = 4'hA,
    ALU_SEQ = 4'hB,
    ALU_SGT = 4'hC,
    ALU_MUL = 4'hD,
    ALU_DIV = 4'hE,
    ALU_MOD = 4'hF
  } alu_op_t;

  // Write-back exception codes
  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_ILLEGAL  = 2'b01,
    EXC_OVERFLOW = 2'b10,
    EXC_DIVZERO  = 2'b11
  } exc_code_t;

  // Primary opcodes understood by the decoder
  typedef enum logic [5:0] {
    OPC_RTYPE = 6'b000000,
    OPC_ADDI  = 6'b001000,
    OPC_ANDI  = 6'b001100,
    OPC_ORI   = 6'b001101,
    OPC_XORI  = 6'b001110
  } opcode_t;

  // R-type funct[5:4] value selecting the ALU group; funct[3:0] is the op
  localparam logic [1:0] FUNCT_ALU_GRP = 2'b10;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Operations that may need extra EXEC cycles in the external ALU
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_MOD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_decode.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_decode
// Purpose : Combinational instruction decoder. Maps opcode/funct to the ALU
//           operation, selects operand B (register or extended immediate),
//           the shift amount and destination register, and flags illegal
//           encodings.
// Ports   : instr_i    - 32-bit instruction word
//           rs_val_i   - rs register value (operand A)
//           rt_val_i   - rt register value (R-type operand B)
//           op_o       - 4-bit ALU operation
//           data_a_o   - operand A
//           data_b_o   - operand B
//           shamt_o    - shift amount (R-type only, else 0)
//           rd_o       - destination register (rd for R-type, rt for I-type)
//           illegal_o  - encoding not supported
// Revision: 1.0 - initial release
// ============================================================================
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] rs_val_i,
  input  logic [31:0] rt_val_i,
  output logic [3:0]  op_o,
  output logic [31:0] data_a_o,
  output logic [31:0] data_b_o,
  output logic [4:0]  shamt_o,
  output logic [4:0]  rd_o,
  output logic        illegal_o
);

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic        w_unused_rs;

  assign w_opcode    = instr_i[31:26];
  assign w_rt        = instr_i[20:16];
  assign w_rd        = instr_i[15:11];
  assign w_shamt     = instr_i[10:6];
  assign w_funct     = instr_i[5:0];
  assign w_imm       = instr_i[15:0];
  // rs field only names the register; its value arrives on rs_val_i
  assign w_unused_rs = ^instr_i[25:21];

  assign data_a_o = rs_val_i;

  always_comb begin
    op_o      = ALU_ADD;
    data_b_o  = '0;
    shamt_o   = '0;
    rd_o      = w_rt;
    illegal_o = 1'b1;
    case (w_opcode)
      OPC_RTYPE: begin
        if (w_funct[5:4] == FUNCT_ALU_GRP) begin
          illegal_o = 1'b0;
          op_o      = w_funct[3:0];
          data_b_o  = rt_val_i;
          shamt_o   = w_shamt;
          rd_o      = w_rd;
        end
      end
      OPC_ADDI: begin
        illegal_o = 1'b0;
        op_o      = ALU_ADD;
        data_b_o  = {{16{w_imm[15]}}, w_imm};
      end
      // logical immediates are zero-extended
      OPC_ANDI: begin
        illegal_o = 1'b0;
        op_o      = ALU_AND;
        data_b_o  = {16'h0000, w_imm};
      end
      OPC_ORI: begin
        illegal_o = 1'b0;
        op_o      = ALU_OR;
        data_b_o  = {16'h0000, w_imm};
      end
      OPC_XORI: begin
        illegal_o = 1'b0;
        op_o      = ALU_XOR;
        data_b_o  = {16'h0000, w_imm};
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_ctrl
// Purpose : Execute-stage sequencer for a shared combinational 32-bit ALU.
//           Accepts one instruction per handshake, drives registered ALU
//           operands, captures the ALU result/flags and returns a write-back
//           response with exception status. One instruction in flight.
// Config  : ALU_MULDIV_STALL_EN - when defined, ops D/E/F stay in EXEC for
//           MULDIV_CYCLES cycles; otherwise every legal op takes one cycle.
// Ports   : clock, reset               - clock, synchronous active-high reset
//           in_valid/in_ready          - instruction handshake
//           in_instr, in_rs_val/rt_val - instruction and register operands
//           alu_operation/dataA/dataB/shamt - registered ALU inputs
//           alu_saida, alu_zero, alu_of     - ALU result and flags
//           out_valid/out_ready        - response handshake
//           out_result, out_zero, out_rd, out_exc, out_exc_code - response
// Revision: 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs_val,
  input  logic [31:0] in_rt_val,
  output logic [3:0]  alu_operation,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_saida,
  input  logic        alu_zero,
  input  logic        alu_of,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic [4:0]  out_rd,
  output logic        out_exc,
  output logic [1:0]  out_exc_code
);

  state_t      state_q;
  state_t      state_d;

  logic [3:0]  alu_op_q;
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic [4:0]  alu_shamt_q;
  logic [31:0] out_result_q;
  logic        out_zero_q;
  logic [4:0]  out_rd_q;
  logic        out_exc_q;
  logic [1:0]  out_exc_code_q;

  logic [3:0]  w_op;
  logic [31:0] w_data_a;
  logic [31:0] w_data_b;
  logic [4:0]  w_shamt;
  logic [4:0]  w_rd;
  logic        w_illegal;
  logic        w_accept;
  logic        w_exec_done;
  logic        w_capture;
  logic [1:0]  w_cap_code;

  alu_issue_decode u_decode (
    .instr_i   (in_instr),
    .rs_val_i  (in_rs_val),
    .rt_val_i  (in_rt_val),
    .op_o      (w_op),
    .data_a_o  (w_data_a),
    .data_b_o  (w_data_b),
    .shamt_o   (w_shamt),
    .rd_o      (w_rd),
    .illegal_o (w_illegal)
  );

  assign w_accept  = in_valid && (state_q == ST_IDLE);
  assign w_capture = (state_q == ST_EXEC) && w_exec_done;

`ifdef ALU_MULDIV_STALL_EN
  localparam logic [3:0] c_muldiv_hold = 4'(MULDIV_CYCLES);

  // Remaining EXEC cycles including the current one; EXEC ends at count 1
  logic [3:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else if (w_accept) begin
      cnt_q <= is_muldiv(w_op) ? c_muldiv_hold : 4'd1;
    end else if ((state_q == ST_EXEC) && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign w_exec_done = (cnt_q <= 4'd1);
`else
  // Hold length is irrelevant without the stall feature
  localparam logic [3:0] c_muldiv_hold_unused = 4'(MULDIV_CYCLES);

  assign w_exec_done = 1'b1;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; illegal instructions skip EXEC and answer at once
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)    state_d = w_illegal ? ST_RESP : ST_EXEC;
      ST_EXEC: if (w_exec_done) state_d = ST_RESP;
      ST_RESP: if (out_ready)   state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_RESP);
  end

  // Exception classification of the ALU flags at capture
  always_comb begin
    w_cap_code = EXC_NONE;
    if (alu_of) begin
      if ((alu_op_q == ALU_ADD) || (alu_op_q == ALU_SUB)) begin
        w_cap_code = EXC_OVERFLOW;
      end else if ((alu_op_q == ALU_DIV) || (alu_op_q == ALU_MOD)) begin
        w_cap_code = EXC_DIVZERO;
      end
    end
  end

  // Operand and response registers. ALU inputs only change on a legal
  // accept so the ALU sees stable operands through EXEC and RESP.
  always_ff @(posedge clock) begin
    if (reset) begin
      alu_op_q       <= 4'd0;
      alu_a_q        <= 32'd0;
      alu_b_q        <= 32'd0;
      alu_shamt_q    <= 5'd0;
      out_result_q   <= 32'd0;
      out_zero_q     <= 1'b0;
      out_rd_q       <= 5'd0;
      out_exc_q      <= 1'b0;
      out_exc_code_q <= EXC_NONE;
    end else begin
      if (w_accept && !w_illegal) begin
        alu_op_q    <= w_op;
        alu_a_q     <= w_data_a;
        alu_b_q     <= w_data_b;
        alu_shamt_q <= w_shamt;
        out_rd_q    <= w_rd;
      end
      if (w_accept && w_illegal) begin
        out_result_q   <= 32'd0;
        out_zero_q     <= 1'b0;
        out_rd_q       <= w_rd;
        out_exc_q      <= 1'b1;
        out_exc_code_q <= EXC_ILLEGAL;
      end
      if (w_capture) begin
        out_exc_q      <= (w_cap_code != EXC_NONE);
        out_exc_code_q <= w_cap_code;
        out_result_q   <= (w_cap_code != EXC_NONE) ? 32'd0 : alu_saida;
        out_zero_q     <= (w_cap_code != EXC_NONE) ? 1'b0 : alu_zero;
      end
    end
  end

  assign alu_operation = alu_op_q;
  assign alu_dataA     = alu_a_q;
  assign alu_dataB     = alu_b_q;
  assign alu_shamt     = alu_shamt_q;
  assign out_result    = out_result_q;
  assign out_zero      = out_zero_q;
  assign out_rd        = out_rd_q;
  assign out_exc       = out_exc_q;
  assign out_exc_code  = out_exc_code_q;

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Execute-stage sequencer that drives the shared 32-bit ALU from the initiator side. Accepts one decoded-register instruction per handshake, decodes opcode/funct into the 4-bit ALU operation code, registers operands, samples ALU result/zero/overflow, and returns a write-back response with exception status. Sits between register read and write-back; the ALU itself stays combinational and external.

## Interface
Parameters:
- MULDIV_CYCLES, 4: EXEC hold cycles for ops 0xD/0xE/0xF (range 1–15; used only with the stall feature).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  instruction offered
- in_ready  out  1  high only in IDLE
- in_instr  in  32  opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0]
- in_rs_val, in_rt_val  in  32 each  register operands
- alu_operation  out  4  to ALU
- alu_dataA, alu_dataB  out  32 each  to ALU
- alu_shamt  out  5  to ALU
- alu_saida  in  32  ALU result
- alu_zero, alu_of  in  1 each  ALU flags
- out_valid  out  1  response valid
- out_ready  in  1  consumer accepts
- out_result  out  32  result (0 on exception)
- out_zero  out  1  alu_zero captured
- out_rd  out  5  destination register
- out_exc  out  1  exception flag
- out_exc_code  out  2  00 none, 01 illegal, 10 overflow, 11 divide-by-zero

## Operation
- ALU op codes: 0 add, 1 sub, 2 inc, 3 dec, 4 and, 5 or, 6 xor, 7 not, 8 sll, 9 srl, A slt, B seq, C sgt, D mul, E div, F mod.
- R-type (opcode 000000): legal iff funct[5:4]=10; op=funct[3:0]; A=rs_val, B=rt_val, shamt=instr[10:6]; out_rd=rd.
- I-type: 001000 addi (op 0, B=sign-extended imm), 001100 andi (op 4), 001101 ori (op 5), 001110 xori (op 6), logic immediates zero-extended; A=rs_val; shamt=0; out_rd=rt.
- Any other opcode/funct: illegal.
- FSM: IDLE → (in_valid) EXEC if legal, RESP if illegal. EXEC → RESP after hold count expires; capture alu_saida/alu_zero/alu_of at last EXEC edge. RESP → IDLE when out_ready.
- Exception mapping at capture: alu_of with op 0/1 → code 10; alu_of with op E/F → code 11; illegal → code 01. Any exception forces out_result=0, out_zero=0.
- alu_* outputs are registered at accept and held stable through EXEC and RESP; in IDLE they hold last value.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, out_result 0, out_zero 0, out_rd 0, out_exc 0, out_exc_code 00, alu_operation 0, alu_dataA/B 0, alu_shamt 0.
- Accept at edge E0 (in_valid & in_ready). Legal single-cycle op: EXEC during E0–E1, out_valid high from E1. Illegal: out_valid high from E0.
- out_valid held with all out_* stable until out_ready sampled high; IDLE (in_ready 1) next cycle. No accept in the same cycle as response completion (one instruction in flight, max throughput 1 per 3 cycles).
- in_valid while in_ready=0 ignored; in_* need only be valid at accept edge.
- reset in any state: next cycle IDLE, in-flight instruction discarded, no response.

## Configuration
- ALU_MULDIV_STALL_EN defined: ops D/E/F hold EXEC for MULDIV_CYCLES cycles (4-bit down-counter loaded at accept); out_valid from E0+MULDIV_CYCLES. Other ops unaffected.
- Undefined: every legal op spends exactly one EXEC cycle; counter and parameter unused.

## Structure
- Shared alu_pkg: op-code constants (ALU_ADD…ALU_MOD), exc-code constants, opcode/funct constants, FSM state typedef.
- One combinational sub-module alu_issue_decode: instr → op, operand select, immediate extend, rd, illegal flag.

## Test plan
- addi rs_val=5, imm=0xFFFF → op 0, B=0xFFFFFFFF, out_result 4, out_rd=rt, out_valid at E0+1.
- R-type add 0x7FFFFFFF+1 with alu_of=1 → out_exc 1, code 10, out_result 0.
- R-type div (funct 101110) rt_val=0, alu_of=1 → code 11; with ALU_MULDIV_STALL_EN, MULDIV_CYCLES=4, out_valid exactly at E0+4.
- opcode 111111 → out_exc 1, code 01, out_valid at E0, alu_* unchanged.
- out_ready held low 5 cycles in RESP → out_* stable, in_ready 0, second in_valid ignored.
- reset asserted mid-EXEC → next cycle IDLE, out_valid 0, all outputs at reset values.
